// File: rtl/spi_arb_pkg.sv
// Shared state encoding, widths and power-up configuration table for the
// two-requester SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CFG_N_DEF = 3;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CFG_SND  = 3'd1,
    CFG_WAIT = 3'd2,
    IDLE     = 3'd3,
    XFER     = 3'd4
  } arb_state_e;

  // Power-up configuration words; indices past the table read as zero.
  function automatic logic [DATA_W-1:0] cfg_rom(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h0D02;
      8'd1:    return 16'h1160;
      8'd2:    return 16'h1440;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_txn_arb.sv
// Arbitrates two requesters onto one external SPI transaction engine after a
// power-up delay and a fixed configuration sequence.
module spi_txn_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned PWR_DLY = 65535,
  parameter int unsigned CFG_N   = CFG_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              snd,
  output logic [DATA_W-1:0] cmd,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_resp,
  output logic              cfg_done
);

  localparam int unsigned      IDX_W    = (CFG_N > 1) ? $clog2(CFG_N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_N - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic              sent_q, sent_d;
  logic              snd_d, done0_d, done1_d, cfg_done_d;
  logic [DATA_W-1:0] cmd_d, rdata_d;
  logic [1:0]        gnt;
  logic              grant_ok;

  rr_arb2 u_rr_arb2 (
    .req      ({req1, req0}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign idx_inc  = IDX_W'(idx_q + 1'b1);
  // No new grant while a completion pulse is still on the wire.
  assign grant_ok = (|gnt) && !(done0 || done1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWR_WAIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      sent_q     <= 1'b0;
      snd        <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      cfg_done   <= 1'b0;
      cmd        <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      sent_q     <= sent_d;
      snd        <= snd_d;
      done0      <= done0_d;
      done1      <= done1_d;
      cfg_done   <= cfg_done_d;
      cmd        <= cmd_d;
      rdata      <= rdata_d;
    end
  end

  // Next-state and output decode; snd/cmd are launched on entry to CFG_SND.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    sent_d     = sent_q;
    snd_d      = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    cfg_done_d = cfg_done;
    cmd_d      = cmd;
    rdata_d    = rdata;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = CFG_SND;
          snd_d   = 1'b1;
          cmd_d   = cfg_rom(8'(idx_q));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CFG_SND: begin
        state_d = CFG_WAIT;
      end

      CFG_WAIT: begin
        if (spi_done) begin
          if (idx_q == IDX_LAST) begin
            state_d    = IDLE;
            cfg_done_d = 1'b1;
          end else begin
            idx_d   = idx_inc;
            state_d = CFG_SND;
            snd_d   = 1'b1;
            cmd_d   = cfg_rom(8'(idx_inc));
          end
        end
      end

      IDLE: begin
        if (grant_ok) begin
          state_d    = XFER;
          owner_d    = gnt[1];
          last_gnt_d = gnt[1];
          sent_d     = 1'b0;
          cmd_d      = gnt[1] ? wdata1 : wdata0;
        end
      end

      XFER: begin
        // First XFER clock launches the engine; completion is owned regardless of req.
        if (!sent_q) begin
          snd_d  = 1'b1;
          sent_d = 1'b1;
        end else if (spi_done) begin
          rdata_d = spi_resp;
          done0_d = !owner_q;
          done1_d = owner_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = PWR_WAIT;
      end
    endcase
  end

  a_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done0 && done1));
  a_snd_pulse: assert property (@(posedge clk) disable iff (!rst_n) snd |=> !snd);
  a_cfg_hold:  assert property (@(posedge clk) disable iff (!rst_n) cfg_done |=> cfg_done);

endmodule

// File: tb/tb_spi_txn_arb.sv
// Directed bench for spi_txn_arb: power-up/config sequence, pending requests,
// round-robin arbitration, mid-transaction drop/reset and stray completions.
module tb_spi_txn_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1;
  logic [15:0] rdata;
  logic        snd;
  logic [15:0] cmd;
  logic        spi_done;
  logic [15:0] spi_resp;
  logic        cfg_done;

  int n_vec;
  int n_err;
  int snd_cnt;
  int done0_cnt;
  int done1_cnt;

  logic [15:0] exp_rom [3];

  spi_txn_arb #(
    .PWR_DLY (16),
    .CFG_N   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .snd      (snd),
    .cmd      (cmd),
    .spi_done (spi_done),
    .spi_resp (spi_resp),
    .cfg_done (cfg_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters sampled mid-cycle.
  initial begin
    snd_cnt = 0;
    done0_cnt = 0;
    done1_cnt = 0;
  end
  always @(negedge clk) begin
    if (snd)   snd_cnt   <= snd_cnt + 1;
    if (done0) done0_cnt <= done0_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns as soon as snd is observed high, or ok=0 after the budget.
  task automatic wait_snd(output bit ok, output logic [15:0] c);
    ok = 1'b0;
    c  = '0;
    for (int i = 0; i < 200; i++) begin
      if (snd) begin
        ok = 1'b1;
        c  = cmd;
        break;
      end
      tick();
    end
  endtask

  // Engine model: completion sampled lat clocks after the observed snd.
  task automatic spi_reply(input int lat, input logic [15:0] resp);
    repeat (lat - 1) tick();
    spi_done = 1'b1;
    spi_resp = resp;
    tick();
    spi_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++; if (snd !== 1'b0)      begin n_err++; $display("FAIL reset_snd: got %b want 0", snd); end
    n_vec++; if (done0 !== 1'b0)    begin n_err++; $display("FAIL reset_done0: got %b want 0", done0); end
    n_vec++; if (done1 !== 1'b0)    begin n_err++; $display("FAIL reset_done1: got %b want 0", done1); end
    n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL reset_cfg_done: got %b want 0", cfg_done); end
    n_vec++; if (cmd !== 16'h0000)  begin n_err++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_vec++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
  endtask

  // Releases reset and walks the power-up wait plus all config writes.
  task automatic test_power_up(input bit raise_req0);
    int          first;
    int          s0, d0, d1;
    bit          ok;
    logic [15:0] c;
    first = 0;
    s0 = snd_cnt; d0 = done0_cnt; d1 = done1_cnt;
    rst_n = 1'b1;
    for (int t = 1; t <= 24 && first == 0; t++) begin
      tick();
      if (raise_req0 && t == 5) begin
        req0   = 1'b1;
        wdata0 = 16'hA5A5;
      end
      if (snd) first = t;
    end
    n_vec++; if (first != 16) begin n_err++; $display("FAIL pwr_first_snd: got clock %0d want 16", first); end
    for (int k = 0; k < 3; k++) begin
      wait_snd(ok, c);
      n_vec++; if (!ok || c !== exp_rom[k]) begin n_err++; $display("FAIL cfg_cmd%0d: got %h (seen %0b) want %h", k, c, ok, exp_rom[k]); end
      n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL cfg_done_early%0d: got %b want 0", k, cfg_done); end
      spi_reply(40, 16'hF000 + 16'(k));
    end
    n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL cfg_done_rise: got %b want 1", cfg_done); end
    n_vec++; if (snd_cnt - s0 != 3) begin n_err++; $display("FAIL cfg_snd_count: got %0d want 3", snd_cnt - s0); end
    n_vec++; if (done0_cnt != d0 || done1_cnt != d1) begin n_err++; $display("FAIL cfg_no_done: got %0d/%0d want 0/0", done0_cnt - d0, done1_cnt - d1); end
  endtask

  task automatic test_pending_req();
    bit          ok;
    logic [15:0] c;
    int          d0;
    d0 = done0_cnt;
    wait_snd(ok, c);
    n_vec++; if (!ok || c !== 16'hA5A5) begin n_err++; $display("FAIL pend_cmd: got %h (seen %0b) want a5a5", c, ok); end
    spi_reply(40, 16'h1234);
    n_vec++; if (done0 !== 1'b1 || done1 !== 1'b0) begin n_err++; $display("FAIL pend_done: got %b%b want 01", done1, done0); end
    n_vec++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL pend_rdata: got %h want 1234", rdata); end
    req0 = 1'b0;
    tick();
    n_vec++; if (done0 !== 1'b0 || done0_cnt - d0 != 1) begin n_err++; $display("FAIL pend_done_once: got %b cnt %0d want 0 cnt 1", done0, done0_cnt - d0); end
  endtask

  task automatic test_latency_drop();
    repeat (2) tick();
    req1   = 1'b1;
    wdata1 = 16'hBEEF;
    tick();
    n_vec++; if (snd !== 1'b0) begin n_err++; $display("FAIL lat_snd_early: got %b want 0", snd); end
    req1 = 1'b0;
    tick();
    n_vec++; if (snd !== 1'b1 || cmd !== 16'hBEEF) begin n_err++; $display("FAIL lat_snd: got %b/%h want 1/beef", snd, cmd); end
    spi_reply(5, 16'h5678);
    n_vec++; if (done1 !== 1'b1 || done0 !== 1'b0) begin n_err++; $display("FAIL drop_done: got %b%b want 10", done1, done0); end
    n_vec++; if (rdata !== 16'h5678) begin n_err++; $display("FAIL drop_rdata: got %h want 5678", rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [15:0] c;
    logic [15:0] exp_c;
    int          s0;
    s0 = snd_cnt;
    req0 = 1'b1; wdata0 = 16'h1111;
    req1 = 1'b1; wdata1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      wait_snd(ok, c);
      n_vec++; if (!ok || c !== exp_c) begin n_err++; $display("FAIL rr_cmd%0d: got %h (seen %0b) want %h", i, c, ok, exp_c); end
      spi_reply(3, 16'hC000 + 16'(i));
      n_vec++; if (done0 !== (i % 2 == 0) || done1 !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_done%0d: got %b%b want owner %0d", i, done1, done0, i % 2); end
      n_vec++; if (rdata !== 16'hC000 + 16'(i)) begin n_err++; $display("FAIL rr_rdata%0d: got %h want %h", i, rdata, 16'hC000 + 16'(i)); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();
    n_vec++; if (snd_cnt - s0 != 4) begin n_err++; $display("FAIL rr_snd_count: got %0d want 4", snd_cnt - s0); end
  endtask

  task automatic test_stray_done();
    spi_done = 1'b1;
    spi_resp = 16'hDEAD;
    tick();
    spi_done = 1'b0;
    n_vec++; if (done0 !== 1'b0 || done1 !== 1'b0) begin n_err++; $display("FAIL stray_done: got %b%b want 00", done1, done0); end
    n_vec++; if (rdata !== 16'hC003) begin n_err++; $display("FAIL stray_rdata: got %h want c003", rdata); end
    tick();
    req0   = 1'b1;
    wdata0 = 16'h7777;
    tick();
    tick();
    n_vec++; if (snd !== 1'b1 || cmd !== 16'h7777) begin n_err++; $display("FAIL stray_idle: got %b/%h want 1/7777", snd, cmd); end
    spi_reply(4, 16'h4242);
    n_vec++; if (done0 !== 1'b1 || rdata !== 16'h4242) begin n_err++; $display("FAIL stray_next: got %b/%h want 1/4242", done0, rdata); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    bit          ok;
    logic [15:0] c;
    int          d1;
    req1   = 1'b1;
    wdata1 = 16'hABCD;
    wait_snd(ok, c);
    n_vec++; if (!ok || c !== 16'hABCD) begin n_err++; $display("FAIL rst_pre_cmd: got %h (seen %0b) want abcd", c, ok); end
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (cmd !== 16'h0000 || rdata !== 16'h0000) begin n_err++; $display("FAIL rst_async_data: got %h/%h want 0000/0000", cmd, rdata); end
    n_vec++; if (cfg_done !== 1'b0 || snd !== 1'b0 || done1 !== 1'b0) begin n_err++; $display("FAIL rst_async_ctl: got %b%b%b want 000", cfg_done, snd, done1); end
    tick();
    d1 = done1_cnt;
    test_power_up(1'b0);
    n_vec++; if (done1_cnt != d1) begin n_err++; $display("FAIL rst_abandon: got %0d done1 want 0", done1_cnt - d1); end
    wait_snd(ok, c);
    n_vec++; if (!ok || c !== 16'hABCD) begin n_err++; $display("FAIL rst_regrant: got %h (seen %0b) want abcd", c, ok); end
    spi_reply(2, 16'h9999);
    n_vec++; if (done1 !== 1'b1 || rdata !== 16'h9999) begin n_err++; $display("FAIL rst_regrant_done: got %b/%h want 1/9999", done1, rdata); end
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_rom[0] = 16'h0D02;
    exp_rom[1] = 16'h1160;
    exp_rom[2] = 16'h1440;
    rst_n    = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    wdata0   = '0;
    wdata1   = '0;
    spi_done = 1'b0;
    spi_resp = '0;

    test_reset();
    test_power_up(1'b1);
    test_pending_req();
    test_latency_drop();
    test_back_to_back();
    test_stray_done();
    test_reset_mid_xfer();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
